// File: rtl/bpu_reg_pkg.sv
// Shared types for the register bank: operation encoding and its width.
package bpu_reg_pkg;

    localparam int REG_OP_W = 2;

    typedef enum logic [REG_OP_W-1:0] {
        CLR  = 2'b00,
        LOAD = 2'b01,
        INC  = 2'b10,
        DEC  = 2'b11
    } reg_op_e;

endpackage

// File: rtl/register_cell.sv
// One WIDTH-bit register with CLR/LOAD/INC/DEC. The next value and the wrap
// indication are exported combinationally so the bank can build its flags
// from exactly the value that gets written.
module register_cell
    import bpu_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [REG_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    data,
    output logic [WIDTH-1:0]    q,
    output logic [WIDTH-1:0]    nxt,
    output logic                wrap
);

    // Candidate next value and wrap for the requested op (modulo 2^WIDTH).
    always_comb begin
        nxt  = q;
        wrap = 1'b0;
        case (reg_op_e'(op))
            CLR:  nxt = '0;
            LOAD: nxt = data;
            INC: begin
                nxt  = q + WIDTH'(1);
                wrap = (q == '1);
            end
            DEC: begin
                nxt  = q - WIDTH'(1);
                wrap = (q == '0);
            end
        endcase
    end

    // Storage: commit the candidate only when this cell is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/register_bank.sv
// DEPTH x WIDTH register bank with one operation port, two independent
// combinational read ports (zero when disabled, so they can be OR-ed onto a
// shared bus) and registered wrap/zero flags describing the last executed op.
//
// Command qualifier: op_en is a single-cycle strobe with no ready; every
// strobed command with an in-range op_addr executes on that rising edge.
// Out-of-range commands are dropped and leave the flags untouched.
module register_bank
    import bpu_reg_pkg::*;
#(
    parameter int   WIDTH  = 8,
    parameter int   DEPTH  = 4,
    localparam int  ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_en,
    input  logic [REG_OP_W-1:0] op,
    input  logic [ADDR_W-1:0]   op_addr,
    input  logic [WIDTH-1:0]    op_data,
    input  logic                rd_a_en,
    input  logic [ADDR_W-1:0]   rd_a_addr,
    output logic [WIDTH-1:0]    rd_a_data,
    input  logic                rd_b_en,
    input  logic [ADDR_W-1:0]   rd_b_addr,
    output logic [WIDTH-1:0]    rd_b_data,
    output logic                wrap,
    output logic                zero
);

    logic [DEPTH-1:0] cell_en;
    logic [DEPTH-1:0] cell_wrap;
    logic [WIDTH-1:0] cell_q   [DEPTH];
    logic [WIDTH-1:0] cell_nxt [DEPTH];
    logic [WIDTH-1:0] sel_nxt;
    logic             sel_wrap;
    logic             op_valid;

    // Address decode: an out-of-range op_addr matches no cell.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        assign cell_en[i] = op_en && (op_addr == ADDR_W'(i));

        register_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (cell_en[i]),
            .op   (op),
            .data (op_data),
            .q    (cell_q[i]),
            .nxt  (cell_nxt[i]),
            .wrap (cell_wrap[i])
        );
    end

    assign op_valid = |cell_en;

    // Pick the value/wrap of the cell being written (at most one is enabled).
    always_comb begin
        sel_nxt  = '0;
        sel_wrap = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cell_en[i]) begin
                sel_nxt  = cell_nxt[i];
                sel_wrap = cell_wrap[i];
            end
        end
    end

    // Flags follow the last executed op and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
            zero <= 1'b0;
        end else if (op_valid) begin
            wrap <= sel_wrap;
            zero <= (sel_nxt == '0);
        end
    end

    // Read muxes: pre-edge contents, zero when disabled or out of range.
    always_comb begin
        rd_a_data = '0;
        rd_b_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_a_en && (rd_a_addr == ADDR_W'(i))) rd_a_data = cell_q[i];
            if (rd_b_en && (rd_b_addr == ADDR_W'(i))) rd_b_data = cell_q[i];
        end
    end

endmodule
